// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
//
// Purpose:
//   Decode/execute stage for a tiny 8-bit ISA. It holds the instruction
//   register (IR), an 8x8 register file and a RUN/SQUASH/HALT state machine.
//   It tells the fetch stage how to adjust its PC after branches, jumps and
//   halts.
//
//   ISA (IR[7:6]):
//     00 ADD  R[5:3] = R[5:3] + R[2:0]   (mod 256)
//     01 LI   R[5:3] = {5'b0, IR[2:0]}
//     10 BZ   if R[IR[5:3]] == 0, branch by signed IR[2:0]
//     11 JMP  branch by signed IR[5:0]   (8'hFF is HALT, not JMP)
//
//   Fetch computes next-PC = pc + 1 + pcVal whenever pcOverride is 0. While
//   an instruction executes, fetch already presents the instruction that
//   follows it. A branch target of addr+1+off therefore requires
//   pcVal = off - 1. The instruction fetched alongside a taken branch is the
//   wrong path and is discarded in SQUASH.
//
// Configuration macro:
//   DECODE_COND_BRANCH_EN - when defined, opcode 10 is BZ. Otherwise
//                           opcode 10 is a NOP.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high reset
//   instruction  instruction word from fetch, sampled on posedge clk
//   pcVal        PC adjustment to fetch (valid while pcOverride == 0)
//   pcOverride   active-low; 0 = fetch applies pcVal on the next edge
//   wbValid      one-cycle pulse: a register write committed at the last edge
//   wbReg        index of that write
//   wbData       value of that write
//   halted       high while in HALT
//   state_dbg    current state-machine encoding (observation only)
// ---------------------------------------------------------------------------
module instruction_decode #(
   parameter logic [7:0] REG_INIT = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] instruction,
   output logic [7:0] pcVal,
   output logic       pcOverride,
   output logic       wbValid,
   output logic [2:0] wbReg,
   output logic [7:0] wbData,
   output logic       halted,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_SQUASH = 2'd1,
      S_HALT   = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [7:0] ir;
   logic       ir_valid;
   logic [7:0] rf [8];

   logic       wr_en;
   logic [7:0] wr_data;
   logic [2:0] wr_idx;
   logic [7:0] rd_val;
   logic [7:0] rs_val;

   assign wr_idx = ir[5:3];
   assign rd_val = rf[ir[5:3]];
   assign rs_val = rf[ir[2:0]];

   // Next state, fetch control and write decode. The register file is read
   // directly. A write always lands at the edge that ends its execute cycle,
   // so the next instruction already sees the new value and no bypass is
   // needed.
   always_comb begin
      state_nxt  = state;
      pcOverride = 1'b1;
      pcVal      = 8'h00;
      wr_en      = 1'b0;
      wr_data    = 8'h00;

      case (state)
         S_RUN: begin
            if (ir_valid) begin
               if (ir == 8'hFF) begin
                  // Freeze fetch from the halt's own execute cycle onward.
                  pcOverride = 1'b0;
                  pcVal      = 8'hFF;
                  state_nxt  = S_HALT;
               end else begin
                  case (ir[7:6])
                     2'b00: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val + rs_val;
                     end
                     2'b01: begin
                        wr_en   = 1'b1;
                        wr_data = {5'b0, ir[2:0]};
                     end
                     2'b10: begin
`ifdef DECODE_COND_BRANCH_EN
                        if (rd_val == 8'h00) begin
                           pcOverride = 1'b0;
                           pcVal      = {{5{ir[2]}}, ir[2:0]} - 8'd1;
                           state_nxt  = S_SQUASH;
                        end
`endif
                     end
                     default: begin
                        pcOverride = 1'b0;
                        pcVal      = {{2{ir[5]}}, ir[5:0]} - 8'd1;
                        state_nxt  = S_SQUASH;
                     end
                  endcase
               end
            end
         end
         S_SQUASH: begin
            // The wrong-path instruction in IR is dropped without effect.
            state_nxt = S_RUN;
         end
         S_HALT: begin
            pcOverride = 1'b0;
            pcVal      = 8'hFF;
         end
         default: begin
            state_nxt = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_RUN;
         ir       <= 8'h00;
         ir_valid <= 1'b0;
         wbValid  <= 1'b0;
         wbReg    <= 3'd0;
         wbData   <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            rf[i] <= REG_INIT;
         end
      end else begin
         state   <= state_nxt;
         wbValid <= wr_en;
         // IR keeps loading in SQUASH. Only HALT freezes it.
         if (state != S_HALT) begin
            ir       <= instruction;
            ir_valid <= 1'b1;
         end
         if (wr_en) begin
            rf[wr_idx] <= wr_data;
            wbReg      <= wr_idx;
            wbData     <= wr_data;
         end
      end
   end

   assign halted    = (state == S_HALT);
   assign state_dbg = state;

endmodule

// File: tb/tb_instruction_decode.sv
// ---------------------------------------------------------------------------
// tb_instruction_decode
//
// Bench for instruction_decode. A fetch stage and a program memory are
// modelled around the DUT. An ISA-level interpreter predicts the sequence of
// register writes and whether the program halts. Directed programs check
// fetch-control timing, and random programs stress the full pipeline.
// ---------------------------------------------------------------------------
module tb_instruction_decode;

   localparam logic [7:0] REG_INIT_TB = 8'h00;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] instruction;
   logic [7:0] pcVal;
   logic       pcOverride;
   logic       wbValid;
   logic [2:0] wbReg;
   logic [7:0] wbData;
   logic       halted;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   instruction_decode #(.REG_INIT(REG_INIT_TB)) dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .pcVal       (pcVal),
      .pcOverride  (pcOverride),
      .wbValid     (wbValid),
      .wbReg       (wbReg),
      .wbData      (wbData),
      .halted      (halted),
      .state_dbg   (state_dbg)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mem [256];
   logic [10:0] exp_q [$];
   logic [7:0]  pc;
   bit          model_halted;
   int          model_steps;

   // Per-cycle observations: ov/pv are taken before the edge, the others after it.
   logic        ov_tr  [1024];
   logic [7:0]  pv_tr  [1024];
   logic        wbv_tr [1024];
   logic [10:0] wb_tr  [1024];
   logic [7:0]  pc_tr  [1024];
   logic        hlt_tr [1024];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Architectural interpreter: it walks the program by address and records
   // each register write as {reg, data}.
   task automatic run_model(input int max_steps);
      int         p;
      int         r [8];
      int         a;
      int         b;
      int         off;
      int         steps;
      logic [7:0] ins;
      logic [2:0] a3;
      exp_q.delete();
      model_halted = 1'b0;
      p = 0;
      for (int i = 0; i < 8; i++) r[i] = int'(REG_INIT_TB);
      for (steps = 0; steps < max_steps; steps++) begin
         ins = mem[p];
         if (ins == 8'hFF) begin
            model_halted = 1'b1;
            break;
         end
         a  = int'(ins[5:3]);
         b  = int'(ins[2:0]);
         a3 = ins[5:3];
         case (ins[7:6])
            2'b00: begin
               r[a] = (r[a] + r[b]) % 256;
               exp_q.push_back({a3, 8'(r[a])});
               p = (p + 1) & 255;
            end
            2'b01: begin
               r[a] = b;
               exp_q.push_back({a3, 8'(r[a])});
               p = (p + 1) & 255;
            end
            2'b10: begin
`ifdef DECODE_COND_BRANCH_EN
               off = (b >= 4) ? b - 8 : b;
               if (r[a] == 0) p = (p + 1 + off) & 255;
               else p = (p + 1) & 255;
`else
               p = (p + 1) & 255;
`endif
            end
            default: begin
               off = int'(ins[5:0]);
               if (off >= 32) off = off - 64;
               p = (p + 1 + off) & 255;
            end
         endcase
      end
      model_steps = steps;
   endtask

   task automatic fill_mem(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pc = 8'd0;
      instruction = mem[0];
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wbvalid", 32'(wbValid), 32'd0);
      chk("rst_wbreg", 32'(wbReg), 32'd0);
      chk("rst_wbdata", 32'(wbData), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pcoverride", 32'(pcOverride), 32'd1);
      chk("rst_pcval", 32'(pcVal), 32'd0);
      reset = 1'b0;
   endtask

   // Fetch model plus write scoreboard. Inputs change 1 time unit after each edge.
   task automatic run_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         ov_tr[c] = pcOverride;
         pv_tr[c] = pcVal;
         @(posedge clk);
         #1;
         pc = ov_tr[c] ? pc + 8'd1 : pc + 8'd1 + pv_tr[c];
         instruction = mem[pc];
         pc_tr[c]  = pc;
         wbv_tr[c] = wbValid;
         wb_tr[c]  = {wbReg, wbData};
         hlt_tr[c] = halted;
         if (wbValid) begin
            if (exp_q.size() == 0) chk("wb_unexpected", 32'(wbValid), 32'd0);
            else chk("wb_write", 32'(wb_tr[c]), 32'(exp_q.pop_front()));
         end
      end
   endtask

   task automatic end_check(input string tag);
      if (model_halted) begin
         chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
         chk({tag, "_halted"}, 32'(halted), 32'd1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] slot;
      reset = 1'b1;
      instruction = 8'h00;

      // LI R1,5 ; LI R2,3 ; ADD R1,R2 ; HALT
      fill_mem(8'hFF);
      mem[0] = 8'h4D;
      mem[1] = 8'h53;
      mem[2] = 8'h0A;
      run_model(50);
      do_reset();
      run_cycles(10);
      chk("A_wbv1", 32'(wbv_tr[1]), 32'd1);
      chk("A_wb1", 32'(wb_tr[1]), 32'({3'd1, 8'h05}));
      chk("A_wb2", 32'(wb_tr[2]), 32'({3'd2, 8'h03}));
      chk("A_wb3", 32'(wb_tr[3]), 32'({3'd1, 8'h08}));
      chk("A_wbv4", 32'(wbv_tr[4]), 32'd0);
      for (int c = 0; c < 4; c++) chk("A_ov", 32'(ov_tr[c]), 32'd1);
      end_check("A");

      // JMP +4 at address 10. The squash slot holds HALT, then LI.
      for (int v = 0; v < 2; v++) begin
         slot = (v == 0) ? 8'hFF : 8'h7F;
         fill_mem(8'hFF);
         for (int i = 0; i < 10; i++) mem[i] = 8'h40;
         mem[10] = 8'hC4;
         mem[11] = slot;
         mem[12] = 8'h6F;
         mem[13] = 8'h6F;
         mem[14] = 8'h6F;
         mem[15] = 8'h71;
         run_model(50);
         do_reset();
         run_cycles(20);
         chk("B_ov_pre", 32'(ov_tr[10]), 32'd1);
         chk("B_ov", 32'(ov_tr[11]), 32'd0);
         chk("B_pv", 32'(pv_tr[11]), 32'h03);
         chk("B_target", 32'(pc_tr[11]), 32'd15);
         chk("B_jmp_nowb", 32'(wbv_tr[11]), 32'd0);
         chk("B_squash_nowb", 32'(wbv_tr[12]), 32'd0);
         chk("B_ov_squash", 32'(ov_tr[12]), 32'd1);
         chk("B_halt_squash", 32'(hlt_tr[12]), 32'd0);
         chk("B_halt_after", 32'(hlt_tr[13]), 32'd0);
         chk("B_wb15", 32'(wb_tr[13]), 32'({3'd6, 8'h01}));
         chk("B_halt_end", 32'(hlt_tr[14]), 32'd1);
         end_check("B");
      end

      // BZ R3,-2 at address 20 with R3 = 0.
      fill_mem(8'hFF);
      for (int i = 0; i < 20; i++) mem[i] = 8'h40;
      mem[20] = 8'h9E;
      mem[21] = 8'h7F;
      run_model(200);
      do_reset();
      run_cycles(30);
      chk("C0_bz_nowb", 32'(wbv_tr[21]), 32'd0);
`ifdef DECODE_COND_BRANCH_EN
      chk("C0_ov", 32'(ov_tr[21]), 32'd0);
      chk("C0_pv", 32'(pv_tr[21]), 32'hFD);
      chk("C0_target", 32'(pc_tr[21]), 32'd19);
      chk("C0_squash_nowb", 32'(wbv_tr[22]), 32'd0);
`else
      chk("C0_ov", 32'(ov_tr[21]), 32'd1);
      chk("C0_pv", 32'(pv_tr[21]), 32'h00);
      chk("C0_fallthru", 32'(pc_tr[21]), 32'd22);
      chk("C0_next_wb", 32'(wb_tr[22]), 32'({3'd7, 8'h07}));
`endif
      end_check("C0");

      // Same branch with R3 = 1: not taken.
      mem[0] = 8'h59;
      run_model(200);
      do_reset();
      run_cycles(30);
      chk("C1_ov", 32'(ov_tr[21]), 32'd1);
      chk("C1_pv", 32'(pv_tr[21]), 32'h00);
      chk("C1_next_wbv", 32'(wbv_tr[22]), 32'd1);
      chk("C1_next_wb", 32'(wb_tr[22]), 32'({3'd7, 8'h07}));
      end_check("C1");

      // HALT: fetch freezes, later LIs never write, reset clears halted at once.
      fill_mem(8'h53);
      mem[0] = 8'h4D;
      mem[1] = 8'hFF;
      run_model(50);
      do_reset();
      run_cycles(12);
      chk("D_wb1", 32'(wb_tr[1]), 32'({3'd1, 8'h05}));
      chk("D_ov_exec", 32'(ov_tr[2]), 32'd0);
      chk("D_pv_exec", 32'(pv_tr[2]), 32'hFF);
      for (int c = 3; c < 12; c++) begin
         chk("D_ov_hold", 32'(ov_tr[c]), 32'd0);
         chk("D_pv_hold", 32'(pv_tr[c]), 32'hFF);
         chk("D_nowb", 32'(wbv_tr[c]), 32'd0);
         chk("D_halted", 32'(hlt_tr[c]), 32'd1);
         chk("D_pc_frozen", 32'(pc_tr[c]), 32'd2);
      end
      end_check("D");
      #2;
      reset = 1'b1;
      #1;
      chk("D_rst_halted", 32'(halted), 32'd0);
      chk("D_rst_ov", 32'(pcOverride), 32'd1);
      chk("D_rst_pv", 32'(pcVal), 32'd0);
      chk("D_rst_wbv", 32'(wbValid), 32'd0);

      // Random programs with an occasional HALT sprinkled in.
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         run_model(300);
         do_reset();
         run_cycles(model_halted ? 2 * model_steps + 6 : 200);
         end_check("R");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
